serial_reg_writer: RTL and testbench
====================================

# serial_reg_writer

Serial-to-register-bus bridge that drives the `write_strobe`/`address`/`data` write port of the audio signal generator from three chip pins. An external controller clocks 8-bit command frames (3-bit address, 5-bit data) in over a chip-select/clock/data link. The block validates each frame and issues exactly one single-cycle register write per good frame. It is the initiator side of the generator's register-write interface and sits between the pad ring and `signal_generator`.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for each serial pin (legal values 2 or 3).

Ports:
- `clk`  input  1  system clock; the same clock as the signal generator.
- `rst_n`  input  1  reset; synchronous, active-low.
- `ser_cs_n`  input  1  frame select, asynchronous pin, active-low.
- `ser_clk`  input  1  serial bit clock, asynchronous pin; data is sampled on its rising edge.
- `ser_dat`  input  1  serial data, asynchronous pin, MSB first.
- `write_strobe`  output  1  single-cycle register write pulse.
- `address`  output  3  register address; valid while `write_strobe` is high.
- `data`  output  5  register data; valid while `write_strobe` is high.
- `busy`  output  1  high while a frame is open (synchronized `ser_cs_n` low).
- `frame_err`  output  1  single-cycle pulse when a frame is discarded.

## Operation
- Synchronization:
  - Each pin passes through `SYNC_STAGES` flops and then one history flop.
  - Edges are detected by comparing the last synchronizer stage with the history flop.
  - Reset levels: `ser_cs_n` path = 1, `ser_clk` path = 0, `ser_dat` path = 0.
- FSM states: IDLE, SHIFT, HOLD, STROBE, ERR.
  - IDLE:
    - A `ser_cs_n` falling edge clears the 4-bit bit counter and the 8-bit shift register, then goes to SHIFT.
    - `ser_clk` edges are ignored in IDLE.
  - SHIFT:
    - On each `ser_clk` rising edge, shift left and insert the synchronized `ser_dat`; increment the counter.
    - When the counter reaches 8, go to HOLD.
    - A `ser_cs_n` rising edge with counter < 8 goes to ERR.
  - HOLD:
    - A `ser_cs_n` rising edge goes to STROBE.
    - Any `ser_clk` rising edge (a 9th bit) marks the frame overrun; the subsequent `ser_cs_n` rise then goes to ERR instead of STROBE.
  - STROBE:
    - Lasts one cycle: `write_strobe` = 1, `address` = shift[7:5], `data` = shift[4:0].
    - Next state is IDLE.
  - ERR:
    - Lasts one cycle: `frame_err` = 1, no write is issued.
    - Next state is IDLE.
- `address` and `data` are registered. They load only on entry to STROBE and hold their value otherwise.
- `busy` = inverted synchronized `ser_cs_n`. It is independent of FSM state.
- Simultaneous `ser_clk` rise and `ser_cs_n` rise in the same cycle: the `ser_cs_n` rise takes priority and the clock edge is ignored.
- A `ser_cs_n` falling edge detected during STROBE or ERR: that cycle completes, and the FSM goes directly to SHIFT with the counter cleared. The new frame is not lost.
- All addresses 0–7 are forwarded unchanged; the generator decodes and ignores unused ones.

## Timing
- Reset (`rst_n` = 0 at a `clk` edge): all state returns to reset values.
  - Outputs: `write_strobe` = 0, `address` = 0, `data` = 0, `busy` = 0, `frame_err` = 0.
  - FSM = IDLE, counter = 0, shift register = 0.
  - Asserting reset mid-frame drops the frame; no strobe and no `frame_err` are produced for it.
- Latency: a pin transition first sampled at `clk` edge k is acted on by the FSM at edge k + `SYNC_STAGES`.
  - `write_strobe` is high for exactly the one cycle following edge k + `SYNC_STAGES`, where k is the first edge sampling `ser_cs_n` high.
- Serial constraints:
  - Each `ser_clk` high phase and low phase must be ≥ `SYNC_STAGES` + 1 `clk` cycles.
  - `ser_dat` must be stable from 1 `clk` before to `SYNC_STAGES` + 1 `clk` after the `ser_clk` rise.
- Back-to-back writes: minimum 1 idle `clk` between strobes. Maximum write rate is one per frame.

## Configuration
- `SERIAL_PARITY_EN` defined:
  - A frame is 9 bits: 8 payload bits followed by one odd-parity bit.
  - HOLD is entered at count 9.
  - A parity mismatch (XOR of all 9 bits = 0) routes the `ser_cs_n` rise to ERR.
- `SERIAL_PARITY_EN` undefined:
  - A frame is 8 bits with no parity check.
  - The counter, shift register and FSM behave exactly as described in Operation.

## Test plan
- Good frame: 8-bit frame 0b101_00011, `ser_cs_n` released → one `write_strobe` with `address` = 5, `data` = 3; `frame_err` stays 0.
- Short frame: 5 bits, then `ser_cs_n` released → `frame_err` pulses for 1 cycle; no strobe; `address`/`data` keep their previous values.
- Overrun: 9 bits clocked with parity disabled → `frame_err` pulse, no strobe.
- Back-to-back: frames 0x08 then 0xE1, with `ser_cs_n` re-asserted during the first frame's STROBE cycle → strobes with (0,8) then (7,1); no frame lost.
- Reset mid-frame: 4 bits, `rst_n` low for 1 cycle, then `ser_cs_n` released → no strobe, no error; all outputs 0.
- Parity build (`SERIAL_PARITY_EN`): payload 0x43 with parity bit 0 → strobe (2,3); the same payload with parity bit 1 → `frame_err` pulse.

Source files
------------

// File: rtl/serial_reg_writer.sv
// Serial command link (cs/clk/dat) to single-cycle register write bridge.
// Optional odd-parity bit per frame when SERIAL_PARITY_EN is defined.
module serial_reg_writer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_cs_n,
    input  logic       ser_clk,
    input  logic       ser_dat,
    output logic       write_strobe,
    output logic [2:0] address,
    output logic [4:0] data,
    output logic       busy,
    output logic       frame_err
);

`ifdef SERIAL_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif
    localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        HOLD   = 3'd2,
        STROBE = 3'd3,
        ERR    = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_reg, clk_sync_reg, dat_sync_reg, valid_reg;
    logic                   cs_hist_reg, clk_hist_reg, armed_reg;
    logic                   cs_last, clk_last, dat_last;
    logic                   cs_fall, cs_rise, clk_rise;

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic                    overrun_reg, overrun_next;
    logic [2:0]              address_reg;
    logic [4:0]              data_reg;
    logic                    parity_ok;
    logic [7:0]              payload;

    assign cs_last  = cs_sync_reg[SYNC_STAGES-1];
    assign clk_last = clk_sync_reg[SYNC_STAGES-1];
    assign dat_last = dat_sync_reg[SYNC_STAGES-1];

    // A frame already open when reset is released must not appear as a new one:
    // a falling edge only counts once a genuine high level has been sampled.
    assign cs_fall  = armed_reg & cs_hist_reg & ~cs_last;
    assign cs_rise  = ~cs_hist_reg & cs_last;
    assign clk_rise = ~clk_hist_reg & clk_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cs_sync_reg  <= '1;
            clk_sync_reg <= '0;
            dat_sync_reg <= '0;
            valid_reg    <= '0;
            cs_hist_reg  <= 1'b1;
            clk_hist_reg <= 1'b0;
            armed_reg    <= 1'b0;
        end else begin
            cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], ser_cs_n};
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ser_clk};
            dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ser_dat};
            valid_reg    <= {valid_reg[SYNC_STAGES-2:0], 1'b1};
            cs_hist_reg  <= cs_last;
            clk_hist_reg <= clk_last;
            if (valid_reg[SYNC_STAGES-1] && cs_last) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign payload = shift_reg[FRAME_BITS-1 -: 8];
`ifdef SERIAL_PARITY_EN
    assign parity_ok = ^shift_reg;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            shift_reg   <= '0;
            overrun_reg <= 1'b0;
            address_reg <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            shift_reg   <= shift_next;
            overrun_reg <= overrun_next;
            if (state_next == STROBE && state_reg != STROBE) begin
                address_reg <= payload[7:5];
                data_reg    <= payload[4:0];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        shift_next   = shift_reg;
        overrun_next = overrun_reg;
        case (state_reg)
            IDLE: begin
                if (cs_fall) begin
                    cnt_next     = '0;
                    shift_next   = '0;
                    overrun_next = 1'b0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                // cs release wins over a coincident clock edge
                if (cs_rise) begin
                    state_next = ERR;
                end else if (clk_rise) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], dat_last};
                    cnt_next   = cnt_reg + 4'd1;
                    if (cnt_next == FRAME_CNT) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    state_next = (overrun_reg || !parity_ok) ? ERR : STROBE;
                end else if (clk_rise) begin
                    overrun_next = 1'b1;
                end
            end
            STROBE, ERR: begin
                if (cs_fall) begin
                    cnt_next     = '0;
                    shift_next   = '0;
                    overrun_next = 1'b0;
                    state_next   = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        write_strobe = (state_reg == STROBE);
        frame_err    = (state_reg == ERR);
        address      = address_reg;
        data         = data_reg;
        busy         = ~cs_last;
    end

endmodule

// File: tb/tb_serial_reg_writer.sv
// Scoreboard bench for serial_reg_writer: random and directed frames vs. a frame-level model.
module tb_serial_reg_writer;

    localparam int S = 2;
`ifdef SERIAL_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_cs_n = 1'b1;
    logic       ser_clk = 1'b0;
    logic       ser_dat = 1'b0;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       busy;
    logic       frame_err;

    serial_reg_writer #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .ser_cs_n(ser_cs_n), .ser_clk(ser_clk), .ser_dat(ser_dat),
        .write_strobe(write_strobe), .address(address), .data(data),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       is_err;
        bit [2:0] a;
        bit [4:0] d;
        int       k;
    } exp_t;

    exp_t     q[$];
    int       vectors = 0;
    int       miscompares = 0;
    bit [2:0] hold_a = 3'd0;
    bit [4:0] hold_d = 5'd0;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Frame-level reference: a frame is written iff it carried exactly FB bits
    // (and, with parity, the XOR of all bits is 1); otherwise it is an error.
    task automatic push_expect(input logic [15:0] bits, input int n);
        exp_t     e;
        bit [7:0] p;
        bit       ok;
        logic [8:0] f;
        ok = (n == FB);
        p  = 8'(bits >> (FB - 8));
`ifdef SERIAL_PARITY_EN
        f  = bits[8:0];
        ok = ok && (^f == 1'b1);
`endif
        e.k = cyc + 1;
        if (ok) begin
            e.is_err = 1'b0;
            hold_a   = p[7:5];
            hold_d   = p[4:0];
        end else begin
            e.is_err = 1'b1;
        end
        e.a = hold_a;
        e.d = hold_d;
        q.push_back(e);
        $display("frame n=%0d bits=%h -> %s a=%0d d=%0d", n, bits, ok ? "write" : "error", e.a, e.d);
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n);
        int half;
        @(negedge clk);
        ser_cs_n = 1'b0;
        repeat (S + 2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            half = S + 1 + int'($urandom_range(0, 2));
            ser_dat = bits[n-1-i];
            repeat (half) @(negedge clk);
            ser_clk = 1'b1;
            repeat (half) @(negedge clk);
            ser_clk = 1'b0;
        end
        repeat (S + 1) @(negedge clk);
        ser_cs_n = 1'b1;
        push_expect(bits, n);
    endtask

    function automatic logic [15:0] good_frame(input logic [7:0] pl);
`ifdef SERIAL_PARITY_EN
        return {7'd0, pl, ~^pl};
`else
        return {8'd0, pl};
`endif
    endfunction

    // Monitor: pops one expectation per pulse on write_strobe or frame_err
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (write_strobe || frame_err)) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: strobe=%0b err=%0b, expected no event", write_strobe, frame_err);
            end else begin
                e = q.pop_front();
                chk("event_is_err", int'(frame_err), int'(e.is_err));
                chk("event_is_write", int'(write_strobe), int'(!e.is_err));
                chk("event_cycle", cyc, e.k + S);
                chk("address", int'(address), int'(e.a));
                chk("data", int'(data), int'(e.d));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits;
        int          n, r;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        chk("reset_strobe", int'(write_strobe), 0);
        chk("reset_err", int'(frame_err), 0);
        chk("reset_address", int'(address), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_busy", int'(busy), 0);

        // good frame 101_00011
        send_frame(good_frame(8'hA3), FB);
        repeat (4) @(negedge clk);
        // short frame
        send_frame(16'h0015, 5);
        repeat (4) @(negedge clk);
        // overrun: one bit too many
        send_frame({good_frame(8'hA3), 1'b1}, FB + 1);
        repeat (4) @(negedge clk);
        // back-to-back: cs re-asserted during the first STROBE cycle
        send_frame(good_frame(8'h08), FB);
        send_frame(good_frame(8'hE1), FB);
        repeat (4) @(negedge clk);
        chk("busy_mid_idle", int'(busy), 0);
`ifdef SERIAL_PARITY_EN
        send_frame({7'd0, 8'h43, 1'b0}, 9);
        repeat (4) @(negedge clk);
        send_frame({7'd0, 8'h43, 1'b1}, 9);
        repeat (4) @(negedge clk);
`endif

        // reset in the middle of a frame
        @(negedge clk);
        ser_cs_n = 1'b0;
        repeat (S + 2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            ser_dat = i[0];
            repeat (S + 1) @(negedge clk);
            ser_clk = 1'b1;
            repeat (S + 1) @(negedge clk);
            ser_clk = 1'b0;
        end
        chk("busy_in_frame", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold_a = 3'd0;
        hold_d = 5'd0;
        repeat (3) @(negedge clk);
        ser_cs_n = 1'b1;
        repeat (S + 4) @(negedge clk);
        chk("rst_mid_strobe", int'(write_strobe), 0);
        chk("rst_mid_err", int'(frame_err), 0);
        chk("rst_mid_address", int'(address), 0);
        chk("rst_mid_data", int'(data), 0);
        chk("rst_mid_busy", int'(busy), 0);
        $display("reset mid-frame applied");
        repeat (S + 3) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            bits = 16'($urandom);
            if (r < 7) begin
                n = FB;
`ifdef SERIAL_PARITY_EN
                if (r < 5) bits = good_frame(bits[8:1]);
`endif
            end else if (r == 7) begin
                n = int'($urandom_range(0, FB - 1));
            end else begin
                n = FB + int'($urandom_range(1, 2));
            end
            bits = bits & 16'((32'd1 << n) - 1);
            send_frame(bits, n);
            repeat (int'($urandom_range(0, 6))) @(negedge clk);
        end

        for (int w = 0; w < 50 && q.size() != 0; w++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d events still pending, expected 0", q.size());
        end
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
